// File: rtl/uart_pkg.sv
`default_nettype none
//============================================================================
// Module      : uart_pkg
// Description : Shared constants for the UART receiver: frame geometry and
//               the receive state encoding used by uart_rx.
// Revision    : 1.0 - initial release
//============================================================================
package uart_pkg;

  // Payload bits per frame (8N1 / 8E1).
  localparam int DATA_BITS = 8;

  // Frame bit index of the parity bit: data occupies frame bits 0..7, so
  // the parity bit (when present) is the next one.
  localparam int PARITY_BIT_POS = DATA_BITS;

  // Receive state encoding.
  localparam int STATE_W = 3;
  localparam logic [STATE_W-1:0] ST_IDLE      = 3'd0;
  localparam logic [STATE_W-1:0] ST_START     = 3'd1;
  localparam logic [STATE_W-1:0] ST_DATA      = 3'd2;
  localparam logic [STATE_W-1:0] ST_PARITY    = 3'd3;
  localparam logic [STATE_W-1:0] ST_STOP      = 3'd4;
  localparam logic [STATE_W-1:0] ST_WAIT_IDLE = 3'd5;

  // Even-parity bit for a payload: the value that makes the total count of
  // ones (payload + parity bit) even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
//============================================================================
// Module      : uart_rx_sync
// Description : Two-flop synchronizer for the asynchronous serial line.
//               Both flops reset to 1 so the line reads idle after reset.
// Ports       : clk      - system clock
//               reset    - asynchronous active-high reset
//               i_async  - asynchronous input (serial line)
//               o_sync   - synchronized output
// Revision    : 1.0 - initial release
//============================================================================
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
//============================================================================
// Module      : uart_rx
// Description : UART receiver, 8N1 LSB first, mid-bit sampling with a
//               CLKS_PER_BIT oversampling counter. Holds the last byte with
//               a valid/ready handshake, flags framing errors (one-cycle
//               pulse) and overruns (sticky until reset).
// Config      : define UART_RX_PARITY_EN for 8E1 frames; this adds the
//               PARITY state and the parity_err output.
// Ports       : clk        - system clock, rising edge
//               reset      - asynchronous active-high reset
//               rx         - asynchronous serial input, idle high
//               data       - last received byte
//               valid      - data holds an unconsumed byte
//               ready      - consumer accepts data when valid && ready
//               frame_err  - one-cycle pulse, stop bit sampled low
//               overrun    - sticky, byte completed while valid was high
//               busy       - receiver not in IDLE
//               parity_err - (UART_RX_PARITY_EN only) one-cycle pulse on
//                            parity mismatch
// Revision    : 1.0 - initial release
//============================================================================
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1250
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 frame_err,
  output logic                 overrun,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] C_CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0] C_BIT_LAST = BIT_W'(DATA_BITS - 1);

  // ------------------------------------------------------------------
  // Synchronizer
  // ------------------------------------------------------------------
  logic w_rx_s;

  uart_rx_sync u_sync (
    .clk     (clk),
    .reset   (reset),
    .i_async (rx),
    .o_sync  (w_rx_s)
  );

  // ------------------------------------------------------------------
  // Declarations
  // ------------------------------------------------------------------
  logic [STATE_W-1:0]   r_state;
  logic [STATE_W-1:0]   w_next_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [BIT_W-1:0]     r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_frame_err;
  logic                 r_overrun;

  logic w_cnt_last;
  logic w_cnt_half;
  logic w_state_chg;
  logic w_cnt_clr;
  logic w_shift_en;
  logic w_stop_ok;
  logic w_ferr;
  logic w_load;
  logic w_busy;

`ifdef UART_RX_PARITY_EN
  logic r_par_bad;
  logic r_parity_err;
  logic w_par_sample;
  logic w_perr;
`endif

  assign w_cnt_last = (r_cnt == C_CNT_LAST);
  assign w_cnt_half = (r_cnt == C_CNT_HALF);

  // ------------------------------------------------------------------
  // FSM: state register
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ------------------------------------------------------------------
  // FSM: next-state logic
  // ------------------------------------------------------------------
  // IDLE is only ever entered with rx_s high (reset value 1, a high stop
  // sample, a high false-start sample, or WAIT_IDLE seeing high), so a low
  // rx_s observed in IDLE is always a 1->0 transition.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (!w_rx_s) w_next_state = ST_START;
      end
      ST_START: begin
        if (w_cnt_half) w_next_state = w_rx_s ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (w_cnt_last && (r_bit_cnt == C_BIT_LAST)) begin
`ifdef UART_RX_PARITY_EN
          w_next_state = ST_PARITY;
`else
          w_next_state = ST_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (w_cnt_last) w_next_state = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (w_cnt_last) w_next_state = w_rx_s ? ST_IDLE : ST_WAIT_IDLE;
      end
      ST_WAIT_IDLE: begin
        if (w_rx_s) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // ------------------------------------------------------------------
  // FSM: output / strobe logic
  // ------------------------------------------------------------------
  always_comb begin
    w_busy      = (r_state != ST_IDLE);
    w_state_chg = (w_next_state != r_state);
    // The counter restarts on every state change and at each bit boundary,
    // and is held at zero while waiting on the line level.
    w_cnt_clr   = (r_state == ST_IDLE) || (r_state == ST_WAIT_IDLE) ||
                  w_state_chg || w_cnt_last;
    w_shift_en  = (r_state == ST_DATA) && w_cnt_last;
    w_stop_ok   = (r_state == ST_STOP) && w_cnt_last && w_rx_s;
    w_ferr      = (r_state == ST_STOP) && w_cnt_last && !w_rx_s;
`ifdef UART_RX_PARITY_EN
    w_par_sample = (r_state == ST_PARITY) && w_cnt_last;
    w_load       = w_stop_ok && !r_par_bad;
    w_perr       = w_stop_ok && r_par_bad;
`else
    w_load       = w_stop_ok;
`endif
  end

  // ------------------------------------------------------------------
  // Datapath: bit-period counter, bit counter, shift register
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt     <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else begin
      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      if (r_state != ST_DATA) begin
        r_bit_cnt <= '0;
      end else if (w_shift_en) begin
        r_bit_cnt <= r_bit_cnt + BIT_W'(1);
      end

      // LSB arrives first: shift in at the top so it ends at bit 0.
      if (w_shift_en) begin
        r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity is judged at its own mid-bit but only reported once the stop
  // bit is good, so it lines up with the cycle valid would have risen.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_par_bad    <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      if (w_par_sample) begin
        r_par_bad <= (w_rx_s != even_parity(r_shift));
      end
      r_parity_err <= w_perr;
    end
  end

  assign parity_err = r_parity_err;
`endif

  // ------------------------------------------------------------------
  // Output holding register and handshake
  // ------------------------------------------------------------------
  // A byte landing in the same cycle as a handshake keeps valid high with
  // the new byte; landing while valid is unconsumed records an overrun.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_ferr;
      if (w_load) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
        if (r_valid && !ready) begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign data      = r_data;
  assign valid     = r_valid;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
  assign busy      = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
`timescale 1ns/1ps
//============================================================================
// Module      : tb_uart_rx
// Description : Self-checking bench for uart_rx at CLKS_PER_BIT=16.
//               Expected bytes are queued when a frame is sent; a monitor
//               compares them when the receiver presents a new byte.
//               Honours UART_RX_PARITY_EN for the parity scenario.
// Revision    : 1.0 - initial release
//============================================================================
module tb_uart_rx;

  localparam int CPB = 16;
  localparam int MAX_LAT = CPB / 2 + 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic       ready;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
  logic       par_flip = 1'b0;
  int         perr_cycles = 0;
`endif

  always #5 clk = ~clk;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .data       (data),
    .valid      (valid),
    .ready      (ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
`ifdef UART_RX_PARITY_EN
    .parity_err (parity_err),
`endif
    .busy       (busy)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int stop_cyc = 0;
  int valid_cycles = 0;
  int ferr_cycles = 0;

  logic [7:0] exp_q[$];
  logic       valid_q = 1'b0;
  logic [7:0] data_q = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: a byte is presented when valid rises, or when data changes
  // under a still-high valid (overwrite).
  always @(negedge clk) begin
    if (reset) begin
      valid_q = 1'b0;
      data_q  = 8'h00;
    end else begin
      if (valid)     valid_cycles++;
      if (frame_err) ferr_cycles++;
`ifdef UART_RX_PARITY_EN
      if (parity_err) perr_cycles++;
`endif
      if (valid && (!valid_q || data !== data_q)) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_byte: got 0x%02h, none expected", data);
        end else begin
          check("sb_data", {24'h0, data}, {24'h0, exp_q.pop_front()});
          n_checks++;
          if ((cyc - stop_cyc) > MAX_LAT) begin
            n_errors++;
            $display("FAIL latency: got %0d cycles, required <= %0d", cyc - stop_cyc, MAX_LAT);
          end
        end
      end
      valid_q = valid;
      data_q  = data;
    end
  end

  // Drive one frame starting at a falling clock edge.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^b) ^ par_flip;
    repeat (CPB) @(negedge clk);
`endif
    stop_cyc = cyc;
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    rx    = 1'b1;
    ready = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_data",      {24'h0, data}, 32'h00);
    check("rst_valid",     {31'h0, valid}, 32'h0);
    check("rst_frame_err", {31'h0, frame_err}, 32'h0);
    check("rst_overrun",   {31'h0, overrun}, 32'h0);
    check("rst_busy",      {31'h0, busy}, 32'h0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // 0x55 with ready high: single-cycle valid, no errors
    valid_cycles = 0;
    ferr_cycles  = 0;
    exp_q.push_back(8'h55);
    send_byte(8'h55, 1'b1);
    repeat (2 * CPB) @(negedge clk);
    check("t55_valid_cycles", valid_cycles, 1);
    check("t55_frame_err",    ferr_cycles, 0);
    check("t55_overrun",      {31'h0, overrun}, 32'h0);
    check("t55_busy",         {31'h0, busy}, 32'h0);

    // 4-cycle low glitch: false start, back to idle
    valid_cycles = 0;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    check("glitch_busy_hi", {31'h0, busy}, 32'h1);
    rx = 1'b1;
    repeat (8) @(negedge clk);
    check("glitch_busy_lo", {31'h0, busy}, 32'h0);
    repeat (2 * CPB) @(negedge clk);
    check("glitch_no_valid", valid_cycles, 0);

    // 0xA3 with low stop bit, then a 100-cycle break
    valid_cycles = 0;
    ferr_cycles  = 0;
    send_byte(8'hA3, 1'b0);
    repeat (100) @(negedge clk);
    check("brk_busy",       {31'h0, busy}, 32'h1);
    check("brk_frame_errs", ferr_cycles, 1);
    check("brk_no_valid",   valid_cycles, 0);
    check("brk_data_kept",  {24'h0, data}, 32'h55);
    rx = 1'b1;
    repeat (6) @(negedge clk);
    check("brk_busy_end",   {31'h0, busy}, 32'h0);
    check("brk_frame_errs2", ferr_cycles, 1);

    // Back-to-back 0x01, 0x02 with ready low: overrun
    ready = 1'b0;
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h02);
    send_byte(8'h01, 1'b1);
    check("ovr_first_no_ovr", {31'h0, overrun}, 32'h0);
    send_byte(8'h02, 1'b1);
    repeat (CPB) @(negedge clk);
    check("ovr_data",    {24'h0, data}, 32'h02);
    check("ovr_valid",   {31'h0, valid}, 32'h1);
    check("ovr_overrun", {31'h0, overrun}, 32'h1);
    ready = 1'b1;
    repeat (2) @(negedge clk);
    check("ovr_consumed", {31'h0, valid}, 32'h0);
    check("ovr_sticky",   {31'h0, overrun}, 32'h1);

    // Reset during bit 4 of 0xFF, then 0x3C
    valid_cycles = 0;
    ferr_cycles  = 0;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (4 * CPB + CPB / 2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_data",      {24'h0, data}, 32'h00);
    check("mid_rst_valid",     {31'h0, valid}, 32'h0);
    check("mid_rst_frame_err", {31'h0, frame_err}, 32'h0);
    check("mid_rst_overrun",   {31'h0, overrun}, 32'h0);
    check("mid_rst_busy",      {31'h0, busy}, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (12 * CPB) @(negedge clk);
    check("mid_rst_no_valid", valid_cycles, 0);
    check("mid_rst_no_ferr",  ferr_cycles, 0);
    exp_q.push_back(8'h3C);
    send_byte(8'h3C, 1'b1);
    repeat (2 * CPB) @(negedge clk);
    check("t3c_data", {24'h0, data}, 32'h3C);
    check("t3c_valid_cycles", valid_cycles, 1);

`ifdef UART_RX_PARITY_EN
    // 0x07 with parity bit 0 (even parity requires 1)
    valid_cycles = 0;
    perr_cycles  = 0;
    par_flip = 1'b1;
    send_byte(8'h07, 1'b1);
    par_flip = 1'b0;
    repeat (2 * CPB) @(negedge clk);
    check("par_err_pulses", perr_cycles, 1);
    check("par_no_valid",   valid_cycles, 0);
    check("par_data_kept",  {24'h0, data}, 32'h3C);
`endif

    check("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
- REQ-001 Parameter CLKS_PER_BIT, default 1250, clk cycles per serial bit; legal range 4..65535.
- REQ-002 Port clk  input  1  single system clock; all state on rising edge.
- REQ-003 Port reset  input  1  asynchronous, active-high reset.
- REQ-004 Port rx  input  1  asynchronous serial line, idle high, 8N1 frame, LSB first.
- REQ-005 Port data  output  8  last received byte.
- REQ-006 Port valid  output  1  data holds an unconsumed byte.
- REQ-007 Port ready  input  1  consumer accepts data when valid && ready.
- REQ-008 Port frame_err  output  1  one-cycle pulse: stop bit sampled low.
- REQ-009 Port overrun  output  1  sticky flag: byte completed while valid high; cleared by reset only.
- REQ-010 Port busy  output  1  high in every state except IDLE.

Function
- REQ-011 rx SHALL pass a 2-flop synchronizer; all FSM decisions use the synchronized value rx_s.
- REQ-012 States SHALL be IDLE, START, DATA, [PARITY], STOP, WAIT_IDLE.
- REQ-013 IDLE: on rx_s falling (1 then 0), go START and clear the bit counter.
- REQ-014 START: at count CLKS_PER_BIT/2-1, if rx_s=0 go DATA with the counter restarted; if rx_s=1 return to IDLE (false start, no output).
- REQ-015 DATA: sample rx_s every CLKS_PER_BIT cycles at mid-bit into a shift register, LSB first; after 8 samples go PARITY (if enabled) or STOP.
- REQ-016 STOP, mid-bit sample=1: load data, set valid on the next edge, go IDLE.
- REQ-017 STOP, mid-bit sample=0: pulse frame_err for one cycle, leave data and valid unchanged, go WAIT_IDLE.
- REQ-018 WAIT_IDLE: remain until rx_s=1, then go IDLE; a held-low line (break) yields exactly one frame_err.
- REQ-019 valid SHALL clear on the cycle after valid && ready; if a new byte completes in that same cycle, valid stays high and data takes the new byte.
- REQ-020 A byte completing while valid=1 and ready=0 SHALL overwrite data and set overrun.
- REQ-021 Bit counter width SHALL be clog2(CLKS_PER_BIT); it never wraps past CLKS_PER_BIT-1.
- REQ-022 Latency: valid rises within CLKS_PER_BIT/2+3 cycles of the stop bit's leading edge on rx.

Reset
- REQ-023 Reset SHALL force state IDLE, synchronizer flops to 1, counters to 0, data=0x00, valid=0, frame_err=0, overrun=0, busy=0.
- REQ-024 Reset mid-frame SHALL abandon the frame with no valid or error pulse; the first falling edge after release starts a new frame.

Configuration
- REQ-025 Macro UART_RX_PARITY_EN defined: frame is 8E1; PARITY state samples the parity bit at mid-bit; a mismatch raises output parity_err (1-cycle pulse, in the same cycle valid would rise) and suppresses valid/data update; STOP still checks framing.
- REQ-026 Macro undefined: no PARITY state; no parity_err port; 8N1 only.

Structure
- REQ-027 Package uart_pkg SHALL hold the state encoding constants, DATA_BITS=8, and the parity-bit position constant; uart_rx imports it.
- REQ-028 Sub-module uart_rx_sync (2-flop synchronizer, reset value 1) SHALL be separate; everything else is in uart_rx.

Verification (CLKS_PER_BIT=16)
- REQ-029 Send 0x55, ready=1 -> valid one cycle, data=0x55, frame_err=0, overrun=0.
- REQ-030 Low glitch of 4 cycles on idle rx -> returns to IDLE, no valid, busy back to 0 within 12 cycles.
- REQ-031 Send 0xA3 with stop bit=0, then rx held low 100 cycles -> exactly one frame_err pulse, valid stays 0, busy=1 until rx returns high.
- REQ-032 Send 0x01 then 0x02 back-to-back with ready=0 -> data=0x02, valid=1, overrun=1.
- REQ-033 Assert reset during bit 4 of 0xFF -> all outputs at reset values; next frame 0x3C received correctly.
- REQ-034 With UART_RX_PARITY_EN, send 0x07 with wrong parity bit (0) -> parity_err pulse, valid=0, data unchanged.
